b_operand_stage: RTL and testbench
==================================

// Module: b_operand_stage
// PURPOSE
//  Parametrised, registered successor to the ALU B-operand mux. Selects the ALU B operand
//  from register-file read data rd2 or an immediate: sign-extended, zero-extended or upper-placed.
//  Registers the result in a 2-entry skid buffer with valid/ready handshakes on both sides.
//  Sits between decode/register-read and the ALU input register. Absorbs one cycle of ALU
//  back-pressure without a combinational ready path.
// PARAMETERS
//  DATA_W  32  operand width; width of rd2 and b_out
//  IMM_W   16  immediate width; must satisfy 1 <= IMM_W <= DATA_W (elaboration $error otherwise)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst_n      in   1       reset, asynchronous, active-low
//  flush      in   1       synchronous pipeline flush; empties the buffer
//  in_valid   in   1       upstream operand request valid
//  in_ready   out  1       stage can accept; registered (decoded from state only)
//  rd2        in   DATA_W  register-file read port 2 data
//  imm        in   IMM_W   instruction immediate field
//  bsel       in   2       00 rd2 | 01 sign-ext imm | 10 zero-ext imm | 11 imm<<(DATA_W-IMM_W)
//  out_valid  out  1       b_out holds a valid operand
//  out_ready  in   1       ALU consumes b_out this cycle
//  b_out      out  DATA_W  selected operand, driven from the head register
// BEHAVIOUR
//  - Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Operand formation, computed combinationally at input, captured on in_fire:
//      sign-ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}},imm}; zero-ext = {{(DATA_W-IMM_W){1'b0}},imm}.
//      Upper = imm in bits [DATA_W-1:DATA_W-IMM_W], low bits 0.
//      If IMM_W==DATA_W, modes 01/10/11 all yield imm unchanged.
//  - Storage: head register (drives b_out) plus skid register.
//  - FSM states: EMPTY, ONE (head valid), FULL (head + skid valid).
//  - EMPTY: in_fire -> ONE, head <= new operand.
//  - ONE: in_fire & !out_fire -> FULL, skid <= new.
//    out_fire & !in_fire -> EMPTY.
//    in_fire & out_fire -> ONE, head <= new.
//  - FULL: in_ready=0; out_fire -> ONE, head <= skid; no input accepted.
//  - out_valid = (state!=EMPTY); in_ready = (state!=FULL).
//  - Latency: 1 cycle from in_fire to out_valid when empty. Throughput 1/cycle when out_ready=1.
//  - Ordering strictly FIFO; no operand dropped or duplicated except by flush/reset.
//  - flush: highest priority. Next state EMPTY. Same-cycle in_fire and out_fire are discarded.
//    Upstream must treat that transfer as cancelled. Data regs keep stale values.
//  - rst_n low (any time, incl. mid-transfer): state EMPTY, out_valid 0, in_ready 1,
//    b_out 0, skid 0. Buffered operands are lost.
//  - b_out is stable while out_valid & !out_ready (AXI-style hold). Upstream must hold
//    in_valid/rd2/imm/bsel while in_valid & !in_ready.
// CONFIGURATION
//  - Macro BSTAGE_FWD_EN. When defined, adds ports fwd_valid (in, 1) and fwd_data (in, DATA_W).
//    On in_fire with bsel==00 and fwd_valid==1, fwd_data replaces rd2 (EX/MEM forwarding).
//    Immediate modes ignore fwd_*.
//  - Macro not defined: ports absent; bsel==00 always captures rd2. All other behaviour identical.
// TESTING
//  1. Reset with rst_n=0 mid-stream -> out_valid=0, in_ready=1, b_out=0 asynchronously.
//     First beat after release arrives 1 cycle later.
//  2. DATA_W=32, IMM_W=16, imm=16'h8001, bsel 01/10/11, out_ready=1 ->
//     b_out 32'hFFFF8001, 32'h00008001, 32'h80010000 on consecutive cycles.
//  3. bsel=00, rd2=32'hDEADBEEF, in_valid=1, out_ready=1 every cycle ->
//     b_out 32'hDEADBEEF one cycle later, throughput 1/cycle, in_ready stays 1.
//  4. Push A,B with out_ready=0 -> state FULL, in_ready=0, b_out=A held.
//     out_ready=1 -> A, then B, in order; in_ready returns 1 a cycle after first out_fire.
//  5. FULL state, flush=1 with out_ready=1 -> next cycle out_valid=0, in_ready=1.
//     Neither operand is reported consumed.
//  6. (BSTAGE_FWD_EN) bsel=00, rd2=32'h1, fwd_valid=1, fwd_data=32'h2 -> b_out=32'h2.
//     Same stimulus with bsel=01, imm=16'h0003 -> b_out=32'h3.

Source files
------------

// File: rtl/b_operand_stage_if.sv
// Handshake bundle for the B-operand stage: upstream request, downstream operand, flush.
// Latency: none; this file only declares wires.
// Backpressure: in_ready comes from the stage, and the ALU applies out_ready.
// Ports: flush, in_valid/in_ready, rd2, imm, bsel, out_valid/out_ready, b_out
//        plus fwd_valid/fwd_data when BSTAGE_FWD_EN is defined.
// slave  = the stage's view; master = the driver's view (decode/ALU or testbench).
interface b_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rd2;
    logic [IMM_W-1:0]  imm;
    logic [1:0]        bsel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] b_out;
`ifdef BSTAGE_FWD_EN
    logic              fwd_valid;
    logic [DATA_W-1:0] fwd_data;

    modport slave  (input  flush, in_valid, rd2, imm, bsel, out_ready, fwd_valid, fwd_data,
                    output in_ready, out_valid, b_out);
    modport master (output flush, in_valid, rd2, imm, bsel, out_ready, fwd_valid, fwd_data,
                    input  in_ready, out_valid, b_out);
`else
    modport slave  (input  flush, in_valid, rd2, imm, bsel, out_ready,
                    output in_ready, out_valid, b_out);
    modport master (output flush, in_valid, rd2, imm, bsel, out_ready,
                    input  in_ready, out_valid, b_out);
`endif
endinterface

// File: rtl/b_operand_stage.sv
// ALU B-operand select (rd2 / sign-ext / zero-ext / upper imm) into a 2-entry skid buffer.
// Latency: 1 cycle from in_fire to out_valid when empty; 1 operand/cycle sustained.
// Backpressure: absorbs one stalled beat in the skid reg; in_ready is registered.
// Ports: clk, rst_n (async, active-low), bus (b_operand_stage_if.slave).
// Optional macro BSTAGE_FWD_EN: on bsel==00, fwd_data replaces rd2 when fwd_valid is set.
module b_operand_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    b_operand_stage_if.slave   bus
);

    if (IMM_W < 1 || IMM_W > DATA_W) begin : g_bad_param
        $error("b_operand_stage: IMM_W must satisfy 1 <= IMM_W <= DATA_W");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_skid;
    logic              r_out_valid;
    logic              r_in_ready;

    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_upper;
    logic [DATA_W-1:0] w_reg;
    logic [DATA_W-1:0] w_operand;
    logic              w_in_fire;
    logic              w_out_fire;

    // Casts and a shift instead of replication, so IMM_W == DATA_W needs no
    // zero-width special case: all three immediate modes collapse to imm.
    assign w_zext  = DATA_W'(bus.imm);
    assign w_sext  = DATA_W'($signed(bus.imm));
    assign w_upper = w_zext << (DATA_W - IMM_W);

`ifdef BSTAGE_FWD_EN
    assign w_reg = bus.fwd_valid ? bus.fwd_data : bus.rd2;
`else
    assign w_reg = bus.rd2;
`endif

    always_comb begin
        w_operand = w_reg;
        case (bus.bsel)
            2'b01:   w_operand = w_sext;
            2'b10:   w_operand = w_zext;
            2'b11:   w_operand = w_upper;
            default: w_operand = w_reg;
        endcase
    end

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    // The ready and valid outputs are registered next to the state, so no
    // combinational path runs from out_ready to in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_head      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (bus.flush) begin
            // Same-cycle transfers are cancelled; the data registers keep stale contents.
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_head      <= w_operand;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        r_skid     <= w_operand;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (!w_in_fire && w_out_fire) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_in_fire && w_out_fire) begin
                        r_head <= w_operand;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_head     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.b_out     = r_head;
    assign bus.out_valid = r_out_valid;
    assign bus.in_ready  = r_in_ready;

endmodule

// File: tb/tb_b_operand_stage.sv
// Testbench for b_operand_stage: directed steps plus random traffic against a queue model.
// Latency: the model expects 1 cycle from acceptance to output.
// Backpressure: the model accepts while it holds fewer than 2 entries.
module tb_b_operand_stage;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    logic [31:0] q[$];

    b_operand_stage_if #(.DATA_W(32), .IMM_W(16)) bus ();

    b_operand_stage #(.DATA_W(32), .IMM_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Operand expected from the selection rules, using plain arithmetic.
    function automatic logic [31:0] form(input logic [1:0] bs, input logic [31:0] r,
                                         input logic [15:0] im, input logic fv,
                                         input logic [31:0] fd);
        logic [31:0] z;
        z = {16'd0, im};
        case (bs)
            2'd0:    return fv ? fd : r;
            2'd1:    return im[15] ? (z + 32'hFFFF_0000) : z;
            2'd2:    return z;
            default: return z * 32'd65536;
        endcase
    endfunction

    // One clock: the model applies the transfers, then the outputs are compared just after the edge.
    task automatic step();
        bit          fin;
        bit          fout;
        logic        fv;
        logic [31:0] fd;
        logic [31:0] op;
        fv = 1'b0;
        fd = '0;
`ifdef BSTAGE_FWD_EN
        fv = bus.fwd_valid;
        fd = bus.fwd_data;
`endif
        fin  = bus.in_valid && (q.size() < 2);
        fout = (q.size() > 0) && bus.out_ready;
        op   = form(bus.bsel, bus.rd2, bus.imm, fv, fd);
        @(posedge clk);
        if (bus.flush) begin
            q.delete();
        end else begin
            if (fout) void'(q.pop_front());
            if (fin)  q.push_back(op);
        end
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
        chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, q.size() < 2});
        if (q.size() > 0) chk("b_out", bus.b_out, q[0]);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.rd2       = '0;
        bus.imm       = '0;
        bus.bsel      = 2'b00;
        bus.out_ready = 1'b0;
`ifdef BSTAGE_FWD_EN
        bus.fwd_valid = 1'b0;
        bus.fwd_data  = '0;
`endif
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_b_out",     bus.b_out,              32'd0);

        // Immediate modes back to back
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.imm       = 16'h8001;
        bus.bsel = 2'b01; step(); chk("sext",  bus.b_out, 32'hFFFF_8001);
        bus.bsel = 2'b10; step(); chk("zext",  bus.b_out, 32'h0000_8001);
        bus.bsel = 2'b11; step(); chk("upper", bus.b_out, 32'h8001_0000);
        bus.in_valid = 1'b0; step();

        // rd2 streaming at full rate
        bus.bsel = 2'b00; bus.rd2 = 32'hDEAD_BEEF; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_b_out",    bus.b_out, 32'hDEAD_BEEF);
            chk("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
        end
        bus.in_valid = 1'b0; step();

        // Fill the buffer under back-pressure, then drain in order
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.rd2 = 32'h1111_1111; step();
        bus.rd2 = 32'h2222_2222; step();
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("full_b_out_A",  bus.b_out, 32'h1111_1111);
        bus.in_valid = 1'b0; step();
        chk("hold_b_out_A",  bus.b_out, 32'h1111_1111);
        bus.out_ready = 1'b1; step();
        chk("drain_b_out_B", bus.b_out, 32'h2222_2222);
        chk("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);

        // Flush while full with the ALU ready
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.rd2 = 32'h3333_3333; step();
        bus.rd2 = 32'h4444_4444; step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flush = 1'b1; step();
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_in_ready",  {31'd0, bus.in_ready},  32'd1);
        bus.flush = 1'b0; step();

`ifdef BSTAGE_FWD_EN
        bus.bsel = 2'b00; bus.rd2 = 32'h1; bus.imm = 16'h0003;
        bus.fwd_valid = 1'b1; bus.fwd_data = 32'h2; bus.in_valid = 1'b1;
        step(); chk("fwd_rd2", bus.b_out, 32'h2);
        bus.bsel = 2'b01;
        step(); chk("fwd_imm", bus.b_out, 32'h3);
        bus.in_valid = 1'b0; bus.fwd_valid = 1'b0; step();
`endif

        // Random traffic with occasional flush
        for (int i = 0; i < 1500; i++) begin
            if (!(bus.in_valid && q.size() == 2)) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.rd2      = $urandom;
                bus.imm      = 16'($urandom);
                bus.bsel     = 2'($urandom_range(0, 3));
`ifdef BSTAGE_FWD_EN
                bus.fwd_valid = $urandom_range(0, 1) == 1;
                bus.fwd_data  = $urandom;
`endif
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        bus.flush = 1'b0;

        // Asynchronous reset with the buffer full
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.bsel = 2'b00;
        bus.rd2 = 32'h5555_5555; step();
        bus.rd2 = 32'h6666_6666; step();
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        q.delete();
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("arst_b_out",     bus.b_out,              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.rd2 = 32'h7777_7777; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        chk("post_rst_beat", bus.b_out, 32'h7777_7777);
        chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0; step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
